// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One transaction in flight; data has priority, with fetch starvation capped by max_dstreak.
module mem_arbiter #(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 32,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  input  logic          f_flush,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] StreakMax = 4'(MAX_DSTREAK);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic          owner_f_q, owner_f_d;  // 1: fetch owns the current transaction
  logic          discard_q, discard_d;
  logic [3:0]    streak_q, streak_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          f_ack_q, f_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          fetch_ok;
  logic          pick_fetch;

  always_comb begin
    state_d     = state_q;
    owner_f_d   = owner_f_q;
    discard_d   = discard_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    fetch_ok    = f_req && !f_flush;
    pick_fetch  = fetch_ok && (!d_req || (streak_q == StreakMax));

    unique case (state_q)
      StIdle: begin
        discard_d = 1'b0;
        if (!f_req) begin
          streak_d = '0;
        end
        if (d_req || fetch_ok) begin
          mem_req_d = 1'b1;
          state_d   = StIssue;
          if (pick_fetch) begin
            owner_f_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_be_d    = 4'hF;
            mem_addr_d  = f_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end else begin
            owner_f_d   = 1'b0;
            mem_we_d    = d_we;
            mem_be_d    = d_be;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // A waiting fetch is being passed over; count it, saturating.
            if (f_req && (streak_q < StreakMax)) begin
              streak_d = streak_q + 4'd1;
            end
          end
        end
      end

      StIssue: begin
        if (owner_f_q && f_flush && !mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end else if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = StWait;
          if (owner_f_q && f_flush) begin
            discard_d = 1'b1;
          end
        end
      end

      StWait: begin
        if (owner_f_q && f_flush) begin
          discard_d = 1'b1;
        end
        if (mem_rvalid) begin
          state_d = StResp;
          if (owner_f_q) begin
            f_rdata_d = mem_rdata;
            f_ack_d   = !(discard_q || f_flush);
          end else begin
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
            d_ack_d = 1'b1;
          end
        end
      end

      StResp: begin
        discard_d = 1'b0;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_f_q   <= 1'b0;
      discard_q   <= 1'b0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_f_q   <= owner_f_d;
      discard_q   <= discard_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_ack_q     <= f_ack_d;
      d_ack_q     <= d_ack_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: responder memory model plus ack scoreboard.
module tb_mem_arbiter;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned MAXS = 4;

  logic          clk = 1'b1;
  logic          rst;
  logic          f_req, f_flush, f_ack;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          d_req, d_we, d_ack;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(DW), .AW(AW), .MAX_DSTREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct packed { logic is_f; logic [31:0] data; } exp_t;
  typedef struct packed { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } txn_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   ack_total = 0;
  int   exp_acks = 0;
  int   req_cycles = 0;
  int   gnt_delay = 0;
  int   rv_delay = 1;
  exp_t sb[$];
  txn_t log_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Memory responder: grants after gnt_delay stalled cycles, answers rv_delay cycles later.
  int          hold_cnt = 0;
  int          rv_cnt = 0;
  txn_t        snap;
  logic [31:0] rv_data;
  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rv_data;
      end
    end
    if (mem_req) begin
      req_cycles++;
      if (hold_cnt == 0) snap = {mem_we, mem_be, mem_addr, mem_wdata};
      else check("bp_stable", {mem_we, mem_be, mem_addr, mem_wdata}, snap);
      if (hold_cnt >= gnt_delay) begin
        mem_gnt = 1'b1;
        log_q.push_back(snap);
        rv_data  = snap.we ? 32'hBAD0_BAD0 : model(snap.addr);
        rv_cnt   = rv_delay;
        hold_cnt = 0;
      end else begin
        hold_cnt++;
      end
    end else begin
      hold_cnt = 0;
    end
  end

  // Ack monitor: every ack pops one expected response.
  exp_t e_mon;
  always @(negedge clk) begin
    if (f_ack || d_ack) begin
      ack_total++;
      if (sb.size() == 0) begin
        check("unexpected_ack", {f_ack, d_ack}, 2'b00);
      end else begin
        e_mon = sb.pop_front();
        check("ack_owner", {f_ack, d_ack}, {e_mon.is_f, ~e_mon.is_f});
        if (e_mon.is_f) check("f_rdata", f_rdata, e_mon.data);
        else check("d_rdata", d_rdata, e_mon.data);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_acks(input int budget);
    int i = 0;
    while (ack_total < exp_acks && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("ack_count", ack_total, exp_acks);
  endtask

  task automatic check_zero_outs();
    check("zero_mem", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, '0);
    check("zero_resp", {f_ack, d_ack, f_rdata, d_rdata}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] last_load;
  int          n0, r0;
  initial begin
    rst = 1'b1; f_req = 0; f_addr = '0; f_flush = 0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    tick(3);
    check_zero_outs();
    rst = 1'b0;

    // Single fetch, minimum latency.
    f_req = 1; f_addr = 32'h10;
    sb.push_back('{1'b1, 32'h0050_0093}); exp_acks++;
    tick();
    check("f1_mem_req", mem_req, 1'b1);
    check("f1_mem_issue", {mem_we, mem_be, mem_addr}, {1'b0, 4'hF, 32'h10});
    tick();
    check("f1_req_drop", mem_req, 1'b0);
    tick();
    check("f1_ack", f_ack, 1'b1);
    check("f1_rdata_now", f_rdata, 32'h0050_0093);
    f_req = 0;
    tick();
    check("f1_ack_pulse", f_ack, 1'b0);

    // Load, then store must leave d_rdata alone.
    last_load = model(32'h200);
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200;
    sb.push_back('{1'b0, last_load}); exp_acks++;
    wait_acks(50);
    d_req = 0;
    tick();
    n0 = log_q.size();
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b0, last_load}); exp_acks++;
    wait_acks(50);
    d_req = 0; d_we = 0;
    check("st_log_n", log_q.size() - n0, 1);
    check("st_txn", log_q[n0], {1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF});

    // Flush in IDLE blocks the fetch grant.
    tick();
    f_req = 1; f_flush = 1; f_addr = 32'h30;
    tick();
    check("idle_flush_no_grant", mem_req, 1'b0);
    f_req = 0; f_flush = 0;
    tick();

    // Contention: expect D,D,D,D,F twice.
    f_req = 1; f_addr = 32'h40; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h2000;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) sb.push_back('{1'b1, model(32'h40)});
      else sb.push_back('{1'b0, model(32'h2000)});
    end
    exp_acks += 10;
    wait_acks(400);
    f_req = 0; d_req = 0;
    check("cont_sb_empty", sb.size(), 0);
    tick();

    // Backpressure: grant withheld for 5 cycles.
    gnt_delay = 5; n0 = log_q.size(); r0 = req_cycles;
    d_req = 1; d_addr = 32'h300;
    sb.push_back('{1'b0, model(32'h300)}); exp_acks++;
    wait_acks(60);
    d_req = 0;
    gnt_delay = 0;
    check("bp_one_txn", log_q.size() - n0, 1);
    check("bp_req_cycles", req_cycles - r0, 6);
    tick();

    // Flush while in ISSUE with no grant: cancelled.
    gnt_delay = 100; n0 = log_q.size();
    f_req = 1; f_addr = 32'h20;
    tick();
    check("fl_is_req", mem_req, 1'b1);
    f_flush = 1; f_req = 0;
    tick();
    check("fl_is_cancel", mem_req, 1'b0);
    f_flush = 0;
    tick(3);
    check("fl_is_noack", ack_total, exp_acks);
    check("fl_is_notxn", log_q.size() - n0, 0);
    gnt_delay = 0;

    // Flush while in WAIT: response arrives, no ack.
    rv_delay = 3; n0 = log_q.size();
    f_req = 1; f_addr = 32'h24;
    tick(2);
    check("fl_w_wait", mem_req, 1'b0);
    f_flush = 1; f_req = 0;
    tick();
    f_flush = 0;
    tick(4);
    check("fl_w_noack", ack_total, exp_acks);
    check("fl_w_txn", log_q.size() - n0, 1);
    rv_delay = 1;

    // Reset mid-WAIT, then a stray response.
    rv_delay = 4;
    f_req = 1; f_addr = 32'h28;
    tick(2);
    rst = 1; f_req = 0;
    tick();
    rst = 0;
    check_zero_outs();
    tick(4);
    check("rst_noack", ack_total, exp_acks);
    check("rst_idle", mem_req, 1'b0);
    rv_delay = 1;

    f_req = 1; f_addr = 32'h14;
    sb.push_back('{1'b1, model(32'h14)}); exp_acks++;
    wait_acks(50);
    f_req = 0;
    tick(2);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
